seg_disp_sched: RTL and testbench
=================================

Name: seg_disp_sched

Overview:
- Round-robin scheduler that shares the single 4-digit seven-segment display datapath among N_REQ requesters.
- Grants display ownership to one requester at a time and latches its value, saturated to the displayable range.
- Drives the display driver's num/strobe inputs and holds each value on the display for a guaranteed minimum time.
- Sits between button/counter logic and the seven-segment driver in the top level, on the divided display clock.

Parameters:
N_REQ, 4, number of requesters (2..8)
HOLD_CYCLES, 1000, clk cycles a granted value stays displayed (>=1)
MAX_VAL, 9999, saturation ceiling for displayed value

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset
req  input  N_REQ  per-requester display request; level, held until ack
val  input  16*N_REQ  flattened values; requester i at [16*i+15:16*i], unsigned
gnt  output  N_REQ  one-hot ownership, high from LOAD through end of HOLD
ack  output  N_REQ  one-cycle pulse to owner when its hold completes
num  output  16  value to display driver, unsigned, <= MAX_VAL
strobe  output  1  one-cycle pulse: num has just been updated
owner  output  3  index of current/last owner
ovf  output  1  latched value was saturated (valid with strobe, held until next strobe)
busy  output  1  high when state != IDLE

Behaviour:
- Reset (asynchronous, active-low) places the block in the following state:
  - state=IDLE; gnt=0, ack=0, num=0, strobe=0, owner=0, ovf=0, busy=0.
  - Round-robin pointer set so requester 0 has highest priority.
- Reset mid-operation aborts any grant immediately. No ack is issued for the aborted grant.
- All outputs are registered.
- FSM states: IDLE, LOAD, HOLD.
- IDLE, on an edge with req!=0:
  - Pick the first asserted req scanning upward (with wrap) from pointer.
  - owner<=idx, gnt<=onehot(idx), state<=LOAD.
  - With req==0: remain in IDLE; num holds its last value.
- LOAD, single cycle:
  - num<=min(val[owner],MAX_VAL); ovf<=(val[owner]>MAX_VAL).
  - strobe<=1, cnt<=HOLD_CYCLES-1, state<=HOLD.
- HOLD:
  - strobe<=0.
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0: ack[owner]<=1, gnt<=0, pointer<=owner+1 (mod N_REQ), state<=IDLE.
- ack pulse:
  - High exactly one cycle, coincident with the first IDLE cycle.
  - Cleared on the following edge.
- Latency:
  - req seen at edge E gives gnt after E and strobe after E+1.
  - num is stable HOLD_CYCLES cycles starting with the strobe cycle.
  - ack follows after E+1+HOLD_CYCLES.
  - Minimum request-to-request turnaround is 1 IDLE cycle.
- No preemption. Value is sampled once in LOAD; changes to val during HOLD are ignored.
- Owner dropping req during HOLD: hold still completes and ack is still pulsed.
- Owner keeping req high after ack: re-eligible, but at lowest priority relative to the rotated pointer.
- Simultaneous requests: exactly one grant. Fairness: every continuously asserted req is granted within N_REQ grants.
- Saturation compares the full 16 bits. val==MAX_VAL gives no ovf; val==MAX_VAL+1 saturates with ovf=1.
- cnt width is clog2(HOLD_CYCLES)+1 bits. HOLD_CYCLES=1 gives a one-cycle HOLD.

Test Plan:
- Reset with req=4'b1111 held low-reset → all outputs 0. Release reset → grant to requester 0 first (gnt=0001, owner=0).
- HOLD_CYCLES=4, req=0010, val1=1234 → gnt=0010 next cycle, strobe one cycle later with num=1234, ovf=0. num stable 4 cycles, then ack=0010 for one cycle; busy then drops.
- req=1111 held continuously, val_i=i*1111 → grant order 0,1,2,3,0 with num sequence 0,1111,2222,3333,0. Exactly one strobe and one ack per grant.
- Saturation: val2=9999 → num=9999, ovf=0. Then val2=10000 → num=9999, ovf=1. Then val2=65535 → num=9999, ovf=1.
- Mid-operation events:
  - During HOLD, change val of owner and drop its req → num unchanged, ack still issued at the end of hold.
  - Assert reset in HOLD cycle 2 → gnt=0 and num=0 immediately; no ack; next grant goes to requester 0.
- Back-to-back: req=0001 stays high, req=1000 asserted mid-hold → after ack to 0, requester 3 is granted next (pointer rotation), not 0.

Source files
------------

// File: rtl/seg_disp_sched.sv
// seg_disp_sched: round-robin owner of the shared 4-digit seven-segment
// display datapath. One requester at a time is granted. Its value is
// latched once, saturated to MAX_VAL, presented on num with a strobe, and
// held for HOLD_CYCLES clocks. The hold ends with a one-cycle ack to the owner.
//
// Ports:
//   clk     - display clock, rising edge
//   reset   - asynchronous, active-low reset
//   req     - per-requester display request (level, held until ack)
//   val     - flattened 16-bit values, requester i at [16*i+15:16*i]
//   gnt     - one-hot ownership, LOAD through end of HOLD
//   ack     - one-cycle pulse to the owner on the first IDLE cycle after HOLD
//   num     - value to the display driver, never above MAX_VAL
//   strobe  - one-cycle pulse, num has just been updated
//   owner   - index of the current or last owner
//   ovf     - latched value was saturated (valid with strobe, held)
//   busy    - scheduler is not idle
module seg_disp_sched #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned HOLD_CYCLES = 1000,
    parameter int unsigned MAX_VAL     = 9999
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req,
    input  logic [16*N_REQ-1:0]   val,
    output logic [N_REQ-1:0]      gnt,
    output logic [N_REQ-1:0]      ack,
    output logic [15:0]           num,
    output logic                  strobe,
    output logic [2:0]            owner,
    output logic                  ovf,
    output logic                  busy
);

    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [15:0] MAX_V = 16'(MAX_VAL);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [N_REQ-1:0] gnt_q,    gnt_d;
    logic [N_REQ-1:0] ack_q,    ack_d;
    logic [15:0]      num_q,    num_d;
    logic             strobe_q, strobe_d;
    logic [2:0]       owner_q,  owner_d;
    logic             ovf_q,    ovf_d;
    logic             busy_q,   busy_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [2:0]       ptr_q,    ptr_d;

    logic             pick_valid;
    logic [2:0]       pick_idx;
    logic [15:0]      sel_val;

    // (base + off) mod N_REQ, valid while both operands are below N_REQ
    function automatic logic [2:0] wrap_idx(input logic [2:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end
        return 3'(s);
    endfunction

    // Index to one-hot over the requester vector
    function automatic logic [N_REQ-1:0] onehot(input logic [2:0] idx);
        logic [N_REQ-1:0] v;
        v = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            v[j] = (3'(j) == idx);
        end
        return v;
    endfunction

    // Round-robin pick: first asserted req scanning upward from ptr_q
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            for (int unsigned j = 0; j < N_REQ; j++) begin
                if (!pick_valid && req[j] && (3'(j) == wrap_idx(ptr_q, i))) begin
                    pick_valid = 1'b1;
                    pick_idx   = 3'(j);
                end
            end
        end
    end

    // Owner's value mux
    always_comb begin
        sel_val = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (3'(j) == owner_q) begin
                sel_val = val[16*j +: 16];
            end
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        ack_d    = '0;
        num_d    = num_q;
        strobe_d = 1'b0;
        owner_d  = owner_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_idx;
                    gnt_d   = onehot(pick_idx);
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Value is sampled only here; later changes are ignored
                if (sel_val > MAX_V) begin
                    num_d = MAX_V;
                    ovf_d = 1'b1;
                end else begin
                    num_d = sel_val;
                    ovf_d = 1'b0;
                end
                strobe_d = 1'b1;
                cnt_d    = CNT_LOAD;
                state_d  = ST_HOLD;
            end
            ST_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    ack_d   = onehot(owner_q);
                    gnt_d   = '0;
                    ptr_d   = wrap_idx(owner_q, 1);
                    state_d = ST_IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            ack_q    <= '0;
            num_q    <= '0;
            strobe_q <= 1'b0;
            owner_q  <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            num_q    <= num_d;
            strobe_q <= strobe_d;
            owner_q  <= owner_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
        end
    end

    assign gnt    = gnt_q;
    assign ack    = ack_q;
    assign num    = num_q;
    assign strobe = strobe_q;
    assign owner  = owner_q;
    assign ovf    = ovf_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_seg_disp_sched.sv
// Testbench for seg_disp_sched (N_REQ=4, HOLD_CYCLES=4, MAX_VAL=9999).
// Expected display transactions are queued when requests are driven and
// popped when the DUT strobes.
module tb_seg_disp_sched;

    localparam int unsigned N = 4;
    localparam int unsigned H = 4;

    typedef struct packed {
        logic [2:0]  owner;
        logic [15:0] num;
        logic        ovf;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req;
    logic [16*N-1:0] val;
    logic [N-1:0]  gnt, ack;
    logic [15:0]   num;
    logic          strobe, ovf, busy;
    logic [2:0]    owner;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t sb[$];

    seg_disp_sched #(.N_REQ(N), .HOLD_CYCLES(H), .MAX_VAL(9999)) dut (
        .clk(clk), .reset(reset), .req(req), .val(val),
        .gnt(gnt), .ack(ack), .num(num), .strobe(strobe),
        .owner(owner), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    task automatic set_val(input int i, input logic [15:0] v);
        val[16*i +: 16] = v;
    endtask

    task automatic wait_strobe(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (strobe) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_ack(output bit ok, output int strobes);
        ok = 1'b0;
        strobes = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (strobe) strobes++;
            if (ack != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok; int ns; exp_t e;
        reset = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 4; i++) set_val(i, 16'(i * 1111));
        repeat (3) @(negedge clk);
        n_checks++;
        if ({gnt, ack, num, strobe, owner, ovf, busy} !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: gnt=%b ack=%b num=%0d strobe=%b owner=%0d ovf=%b busy=%b, required all 0",
                     gnt, ack, num, strobe, owner, ovf, busy);
        end
        reset = 1'b1;
        sb.push_back('{owner: 3'd0, num: 16'd0, ovf: 1'b0});
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0001 || owner !== 3'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_grant: gnt=%b owner=%0d busy=%b, required 0001 0 1", gnt, owner, busy);
        end
        wait_strobe(ok);
        n_checks++;
        if (!ok || sb.size() == 0) begin
            n_fail++;
            $display("FAIL reset_strobe: seen=%0d queued=%0d, required strobe with queued entry", ok, sb.size());
        end else begin
            e = sb.pop_front();
            if ({owner, num, ovf} !== {e.owner, e.num, e.ovf}) begin
                n_fail++;
                $display("FAIL reset_value: owner=%0d num=%0d ovf=%b, required %0d %0d %b", owner, num, ovf, e.owner, e.num, e.ovf);
            end
        end
        req = '0;
        wait_ack(ok, ns);
        n_checks++;
        if (!ok || ns != 0 || ack !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_ack: ack=%b seen=%0d strobes=%0d, required 0001 1 0", ack, ok, ns);
        end
        @(negedge clk);
        n_checks++;
        if (ack !== 4'b0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: ack=%b busy=%b, required 0000 0", ack, busy);
        end
    endtask

    task automatic test_basic();
        bit ok; exp_t e;
        set_val(1, 16'd1234);
        req = 4'b0010;
        sb.push_back('{owner: 3'd1, num: 16'd1234, ovf: 1'b0});
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0010 || strobe !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_grant: gnt=%b strobe=%b busy=%b, required 0010 0 1", gnt, strobe, busy);
        end
        wait_strobe(ok);
        n_checks++;
        if (!ok || sb.size() == 0) begin
            n_fail++;
            $display("FAIL basic_strobe: seen=%0d queued=%0d, required strobe with queued entry", ok, sb.size());
        end else begin
            e = sb.pop_front();
            if ({owner, num, ovf} !== {e.owner, e.num, e.ovf}) begin
                n_fail++;
                $display("FAIL basic_value: owner=%0d num=%0d ovf=%b, required %0d %0d %b", owner, num, ovf, e.owner, e.num, e.ovf);
            end
        end
        for (int k = 1; k < int'(H); k++) begin
            @(negedge clk);
            n_checks++;
            if (num !== 16'd1234 || strobe !== 1'b0 || ack !== 4'b0000 || gnt !== 4'b0010) begin
                n_fail++;
                $display("FAIL basic_hold_%0d: num=%0d strobe=%b ack=%b gnt=%b, required 1234 0 0000 0010", k, num, strobe, ack, gnt);
            end
        end
        @(negedge clk);
        n_checks++;
        if (ack !== 4'b0010 || gnt !== 4'b0000 || busy !== 1'b0 || num !== 16'd1234) begin
            n_fail++;
            $display("FAIL basic_ack: ack=%b gnt=%b busy=%b num=%0d, required 0010 0000 0 1234", ack, gnt, busy, num);
        end
        req = '0;
        @(negedge clk);
        n_checks++;
        if (ack !== 4'b0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_ack_clear: ack=%b busy=%b, required 0000 0", ack, busy);
        end
    endtask

    task automatic test_round_robin();
        bit ok; int ns; exp_t e;
        logic [2:0] order [5];
        order = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) set_val(i, 16'(i * 1111));
        req = 4'b1111;
        for (int g = 0; g < 5; g++)
            sb.push_back('{owner: order[g], num: 16'(order[g] * 1111), ovf: 1'b0});
        reset = 1'b1;
        for (int g = 0; g < 5; g++) begin
            wait_strobe(ok);
            n_checks++;
            if (!ok || sb.size() == 0) begin
                n_fail++;
                $display("FAIL rr_strobe_%0d: seen=%0d queued=%0d, required strobe with queued entry", g, ok, sb.size());
            end else begin
                e = sb.pop_front();
                if ({owner, num, ovf} !== {e.owner, e.num, e.ovf} || gnt !== (4'b0001 << e.owner)) begin
                    n_fail++;
                    $display("FAIL rr_value_%0d: owner=%0d num=%0d ovf=%b gnt=%b, required %0d %0d %b", g, owner, num, ovf, gnt, e.owner, e.num, e.ovf);
                end
            end
            wait_ack(ok, ns);
            n_checks++;
            if (!ok || ns != 0 || ack !== (4'b0001 << order[g])) begin
                n_fail++;
                $display("FAIL rr_ack_%0d: ack=%b strobes=%0d, required onehot(%0d) with 0 extra strobes", g, ack, ns, order[g]);
            end
            if (g == 4) req = '0;
        end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        bit ok; int ns; exp_t e;
        logic [15:0] vin [3];
        logic        oin [3];
        vin = '{16'd9999, 16'd10000, 16'd65535};
        oin = '{1'b0, 1'b1, 1'b1};
        for (int t = 0; t < 3; t++) begin
            set_val(2, vin[t]);
            sb.push_back('{owner: 3'd2, num: 16'd9999, ovf: oin[t]});
            req = 4'b0100;
            wait_strobe(ok);
            n_checks++;
            if (!ok || sb.size() == 0) begin
                n_fail++;
                $display("FAIL sat_strobe_%0d: seen=%0d queued=%0d, required strobe with queued entry", t, ok, sb.size());
            end else begin
                e = sb.pop_front();
                if ({owner, num, ovf} !== {e.owner, e.num, e.ovf}) begin
                    n_fail++;
                    $display("FAIL sat_value_%0d: owner=%0d num=%0d ovf=%b, required %0d %0d %b", t, owner, num, ovf, e.owner, e.num, e.ovf);
                end
            end
            wait_ack(ok, ns);
            n_checks++;
            if (!ok || ack !== 4'b0100 || ovf !== oin[t]) begin
                n_fail++;
                $display("FAIL sat_ack_%0d: ack=%b ovf=%b, required 0100 %b", t, ack, ovf, oin[t]);
            end
            req = '0;
            @(negedge clk);
        end
    endtask

    task automatic test_mid_hold();
        bit ok; int ns; exp_t e;
        set_val(0, 16'd500);
        sb.push_back('{owner: 3'd0, num: 16'd500, ovf: 1'b0});
        req = 4'b0001;
        wait_strobe(ok);
        n_checks++;
        if (!ok || sb.size() == 0) begin
            n_fail++;
            $display("FAIL mid_strobe: seen=%0d queued=%0d, required strobe with queued entry", ok, sb.size());
        end else begin
            e = sb.pop_front();
            if ({owner, num, ovf} !== {e.owner, e.num, e.ovf}) begin
                n_fail++;
                $display("FAIL mid_value: owner=%0d num=%0d ovf=%b, required %0d %0d %b", owner, num, ovf, e.owner, e.num, e.ovf);
            end
        end
        @(negedge clk);
        set_val(0, 16'd7777);
        req = '0;
        wait_ack(ok, ns);
        n_checks++;
        if (!ok || ack !== 4'b0001 || num !== 16'd500) begin
            n_fail++;
            $display("FAIL mid_ack: ack=%b num=%0d, required 0001 500", ack, num);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_in_hold();
        bit ok; int ns; exp_t e;
        set_val(1, 16'd4321);
        sb.push_back('{owner: 3'd1, num: 16'd4321, ovf: 1'b0});
        req = 4'b0010;
        wait_strobe(ok);
        n_checks++;
        if (!ok || sb.size() == 0) begin
            n_fail++;
            $display("FAIL rih_strobe: seen=%0d queued=%0d, required strobe with queued entry", ok, sb.size());
        end else begin
            e = sb.pop_front();
            if ({owner, num, ovf} !== {e.owner, e.num, e.ovf}) begin
                n_fail++;
                $display("FAIL rih_value: owner=%0d num=%0d ovf=%b, required %0d %0d %b", owner, num, ovf, e.owner, e.num, e.ovf);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (gnt !== 4'b0000 || num !== 16'd0 || busy !== 1'b0 || ack !== 4'b0000) begin
            n_fail++;
            $display("FAIL rih_abort: gnt=%b num=%0d busy=%b ack=%b, required 0000 0 0 0000", gnt, num, busy, ack);
        end
        req = 4'b1111;
        set_val(0, 16'd42);
        @(negedge clk);
        reset = 1'b1;
        sb.push_back('{owner: 3'd0, num: 16'd42, ovf: 1'b0});
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0001 || owner !== 3'd0 || ack !== 4'b0000) begin
            n_fail++;
            $display("FAIL rih_regrant: gnt=%b owner=%0d ack=%b, required 0001 0 0000", gnt, owner, ack);
        end
        req = 4'b0001;
        wait_strobe(ok);
        n_checks++;
        if (!ok || sb.size() == 0) begin
            n_fail++;
            $display("FAIL rih_strobe2: seen=%0d queued=%0d, required strobe with queued entry", ok, sb.size());
        end else begin
            e = sb.pop_front();
            if ({owner, num, ovf} !== {e.owner, e.num, e.ovf}) begin
                n_fail++;
                $display("FAIL rih_value2: owner=%0d num=%0d ovf=%b, required %0d %0d %b", owner, num, ovf, e.owner, e.num, e.ovf);
            end
        end
        wait_ack(ok, ns);
        req = '0;
        n_checks++;
        if (!ok || ack !== 4'b0001) begin
            n_fail++;
            $display("FAIL rih_ack2: ack=%b, required 0001", ack);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit ok; int ns; exp_t e;
        set_val(0, 16'd11);
        set_val(3, 16'd33);
        sb.push_back('{owner: 3'd0, num: 16'd11, ovf: 1'b0});
        req = 4'b0001;
        wait_strobe(ok);
        n_checks++;
        if (!ok || sb.size() == 0) begin
            n_fail++;
            $display("FAIL b2b_strobe0: seen=%0d queued=%0d, required strobe with queued entry", ok, sb.size());
        end else begin
            e = sb.pop_front();
            if ({owner, num, ovf} !== {e.owner, e.num, e.ovf}) begin
                n_fail++;
                $display("FAIL b2b_value0: owner=%0d num=%0d ovf=%b, required %0d %0d %b", owner, num, ovf, e.owner, e.num, e.ovf);
            end
        end
        @(negedge clk);
        req = 4'b1001;
        sb.push_back('{owner: 3'd3, num: 16'd33, ovf: 1'b0});
        wait_ack(ok, ns);
        n_checks++;
        if (!ok || ack !== 4'b0001) begin
            n_fail++;
            $display("FAIL b2b_ack0: ack=%b, required 0001", ack);
        end
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b1000 || owner !== 3'd3) begin
            n_fail++;
            $display("FAIL b2b_rotate: gnt=%b owner=%0d, required 1000 3", gnt, owner);
        end
        wait_strobe(ok);
        n_checks++;
        if (!ok || sb.size() == 0) begin
            n_fail++;
            $display("FAIL b2b_strobe3: seen=%0d queued=%0d, required strobe with queued entry", ok, sb.size());
        end else begin
            e = sb.pop_front();
            if ({owner, num, ovf} !== {e.owner, e.num, e.ovf}) begin
                n_fail++;
                $display("FAIL b2b_value3: owner=%0d num=%0d ovf=%b, required %0d %0d %b", owner, num, ovf, e.owner, e.num, e.ovf);
            end
        end
        wait_ack(ok, ns);
        req = '0;
        n_checks++;
        if (!ok || ack !== 4'b1000) begin
            n_fail++;
            $display("FAIL b2b_ack3: ack=%b, required 1000", ack);
        end
        @(negedge clk);
    endtask

    initial begin
        req = '0;
        val = '0;
        reset = 1'b0;
        test_reset();
        test_basic();
        test_round_robin();
        test_saturation();
        test_mid_hold();
        test_reset_in_hold();
        test_back_to_back();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
